mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Moore-style multicycle control FSM that drives every control input of the multicycle CPU datapath. Control inputs driven: IorD, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite, PCSrc, branch-sense select, ALU op.
- Consumes the decoded 6-bit opcode and produces one control word per cycle.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Keeps a retired-instruction counter and a sticky illegal-opcode trap.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- run  in  1  when low, FSM holds in FETCH without issuing a fetch
- opcode  in  6  opcode field from instruction decoder, sampled in DECODE
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by datapath branch signal
- iord  out  1  0 = instruction from PC, 1 = from ALU-out address
- ir_write  out  1  latch instruction register
- mem_write  out  1  data-memory write strobe
- mem_to_reg  out  1  0 = ALU result, 1 = memory data to register file
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0 = Rt, 1 = Rd
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 1, 10 = sign-extended imm, 11 unused (never driven)
- alu_op  out  4  ALU function select
- pc_src  out  1  0 = ALU result, 1 = zero-extended jump address
- beq_sel  out  1  0 = branch on ALU flag, 1 = branch on inverted flag
- illegal  out  1  sticky; opcode not in ISA
- state_dbg  out  4  current state encoding
- instr_count  out  CNT_W  instructions retired since reset

Behaviour:
- Reset: state = FETCH, instr_count = 0, illegal = 0. All strobes (pc_write, pc_write_cond, ir_write, mem_write, reg_write) = 0 on the cycle after reset asserts. Reset mid-instruction abandons the instruction; no strobe fires in the reset cycle.
- Outputs are a pure combinational decode of the registered state; the latched opcode is used for alu_op/beq_sel. Any output not listed for a state = 0.
- The opcode register loads only in DECODE.

Opcode map (fixed):
- 00xxxx: R-type ALU, alu_op = opcode[3:0]
- 01xxxx: I-type ALU, alu_op = opcode[3:0]
- 100000: LW
- 100001: SW
- 110000: BEQ
- 110001: BNE
- 110010: JMP
- All others: illegal.

States and transitions:
- FETCH: if run = 1, drive iord = 0, ir_write = 1, alu_src_a = 0, alu_src_b = 01, alu_op = ADD, pc_src = 0, pc_write = 1, then go to DECODE. If run = 0, all strobes are 0 and the FSM stays in FETCH.
- DECODE: latch opcode; no strobes. Go to EXEC_R, EXEC_I, MEM_ADDR, BRANCH or JUMP by opcode. Illegal opcode: go to TRAP.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, then WB_R.
- WB_R: reg_dst = 1, reg_write = 1, mem_to_reg = 0, then FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, then WB_I.
- WB_I: reg_dst = 0, reg_write = 1, then FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = ADD. Go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: iord = 1, then MEM_WB.
- MEM_WB: mem_to_reg = 1, reg_dst = 0, reg_write = 1, then FETCH.
- MEM_WR: iord = 1, mem_write = 1, then FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = SUB, pc_src = 0, pc_write_cond = 1; beq_sel = 0 for BEQ, 1 for BNE. Then FETCH.
- JUMP: pc_src = 1, pc_write = 1, then FETCH.
- TRAP: illegal = 1, all strobes 0. Stays in TRAP until reset.

Latency in cycles, FETCH through final state:
- R-type: 4
- I-type: 4
- LW: 5
- SW: 4
- BEQ/BNE: 3
- JMP: 3

Retired-instruction counter:
- instr_count increments by 1 on leaving the final state of each instruction (WB_R, WB_I, MEM_WB, MEM_WR, BRANCH, JUMP).
- Wraps modulo 2^CNT_W.
- Never increments in TRAP or reset.

Other rules:
- run deasserting mid-instruction does not stall. The instruction completes and the FSM then holds in FETCH.
- mem_write and reg_write are never high in the same cycle.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JMP, class prefixes)
  - ALU op constants (ALU_ADD, ALU_SUB)
  - ALUSrcB encodings
  - state encoding constants (4-bit)
- Optional sub-module mc_ctrl_decode: combinational state+opcode to control word. The FSM register, opcode latch and counter stay in the top.

Test Plan:
- Reset then run = 1 with R-type opcode 000010 → states FETCH, DECODE, EXEC_R, WB_R; WB_R shows reg_dst = 1, reg_write = 1, alu_op = 0010 in EXEC_R; instr_count = 1 after 4 cycles.
- LW (100000) → 5 cycles; MEM_RD iord = 1; MEM_WB mem_to_reg = 1, reg_write = 1, reg_dst = 0. Then SW (100001) → MEM_WR mem_write = 1, reg_write = 0; instr_count = 2.
- BEQ (110000) then BNE (110001) → BRANCH state pc_write_cond = 1, alu_op = SUB, beq_sel = 0 then 1; each takes 3 cycles.
- JMP (110010) → JUMP pc_src = 1, pc_write = 1; run = 0 afterwards → FSM holds in FETCH with pc_write = 0, ir_write = 0, instr_count unchanged.
- Opcode 111111 → TRAP, illegal = 1, all strobes 0 for 20 cycles. Reset → illegal = 0, state FETCH, instr_count = 0.
- Assert reset in MEM_ADDR of an SW → mem_write never asserted; next cycle state FETCH. Preload-free wrap check with CNT_W = 4: 16 JMPs → instr_count returns to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU selects,
// FSM state encoding and the packed control word.
package mc_pkg;

    // Opcode class prefixes (opcode[5:4]) and full opcodes
    localparam logic [1:0] OPC_R    = 2'b00;
    localparam logic [1:0] OPC_I    = 2'b01;
    localparam logic [5:0] OP_LW    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b100001;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_JMP   = 6'b110010;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       pc_src;
        logic       beq_sel;
        logic       illegal;
    } ctrl_t;

    // First execution state for a freshly decoded opcode; unknown opcodes trap.
    function automatic state_t dispatch(input logic [5:0] op);
        state_t nxt;
        if (op[5:4] == OPC_R)                   nxt = ST_EXEC_R;
        else if (op[5:4] == OPC_I)              nxt = ST_EXEC_I;
        else if (op == OP_LW || op == OP_SW)    nxt = ST_MEM_ADDR;
        else if (op == OP_BEQ || op == OP_BNE)  nxt = ST_BRANCH;
        else if (op == OP_JMP)                  nxt = ST_JUMP;
        else                                    nxt = ST_TRAP;
        return nxt;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: opcode/run toward the FSM, control word back.
interface mc_control_unit_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       opcode;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             ir_write;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             pc_src;
    logic             beq_sel;
    logic             illegal;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, opcode,
        output pc_write, pc_write_cond, iord, ir_write, mem_write, mem_to_reg,
               reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_src,
               beq_sel, illegal, state_dbg, instr_count
    );

    modport slave (
        output run, opcode,
        input  pc_write, pc_write_cond, iord, ir_write, mem_write, mem_to_reg,
               reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_src,
               beq_sel, illegal, state_dbg, instr_count
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational map from FSM state (plus latched ALU function) to the control word.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_t     state_i,
    input  logic [3:0] alu_fn_i,
    input  logic       run_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // an output unassigned, which would otherwise infer a latch.
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                if (run_i) begin
                    ctrl_o.ir_write  = 1'b1;
                    ctrl_o.alu_src_b = SRCB_ONE;
                    ctrl_o.alu_op    = ALU_ADD;
                    ctrl_o.pc_write  = 1'b1;
                end
            end
            ST_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = alu_fn_i;
            end
            ST_WB_R: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            ST_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = alu_fn_i;
            end
            ST_WB_I: begin
                ctrl_o.reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl_o.iord = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                // BEQ/BNE differ only in opcode bit 0, which picks the flag sense
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.beq_sel       = alu_fn_i[0];
            end
            ST_JUMP: begin
                ctrl_o.pc_src   = 1'b1;
                ctrl_o.pc_write = 1'b1;
            end
            ST_TRAP: begin
                ctrl_o.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM: state register, opcode latch, retired-instruction
// counter; the control word is decoded from the registered state.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mc_control_unit_if.master bus
);

    state_t           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    ctrl_t            ctrl_raw, ctrl;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (bus.run) state_d = ST_DECODE;
            ST_DECODE:   state_d = dispatch(bus.opcode);
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_EXEC_I:   state_d = ST_WB_I;
            ST_MEM_ADDR: state_d = (opcode_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_d = ST_MEM_WB;
            ST_WB_R, ST_WB_I, ST_MEM_WB, ST_MEM_WR,
            ST_BRANCH, ST_JUMP:
                         state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        retire = (state_q == ST_WB_R)   || (state_q == ST_WB_I)   ||
                 (state_q == ST_MEM_WB) || (state_q == ST_MEM_WR) ||
                 (state_q == ST_BRANCH) || (state_q == ST_JUMP);
        opcode_d = (state_q == ST_DECODE) ? bus.opcode : opcode_q;
        count_d  = retire ? count_q + CNT_W'(1) : count_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i  (state_q),
        .alu_fn_i (opcode_q[3:0]),
        .run_i    (bus.run),
        .ctrl_o   (ctrl_raw)
    );

    // An instruction interrupted by reset must not fire a strobe in that cycle
    always_comb begin
        ctrl = ctrl_raw;
        if (reset) ctrl = '0;
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.iord          = ctrl.iord;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.beq_sel       = ctrl.beq_sel;
    assign bus.illegal       = ctrl.illegal;
    assign bus.state_dbg     = state_q;
    assign bus.instr_count   = count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-state control words, latencies,
// counter, trap, run gating, mid-instruction reset and counter wrap.
module tb_mc_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset   = 1'b1;
    logic w_reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mc_control_unit_if #(.CNT_W(32)) bus  ();
    mc_control_unit_if #(.CNT_W(4))  wbus ();

    mc_control_unit #(.CNT_W(32)) dut   (.clk(clk), .reset(reset),   .bus(bus));
    mc_control_unit #(.CNT_W(4))  dut_w (.clk(clk), .reset(w_reset), .bus(wbus));

    // Observed word layout:
    // {pc_write, pc_write_cond, ir_write, mem_write, reg_write} _
    // {iord, mem_to_reg, reg_dst, alu_src_a} _ alu_src_b _ alu_op _
    // {pc_src, beq_sel, illegal} _ state_dbg
    localparam logic [21:0] W_IDLE     = 22'd0;
    localparam logic [21:0] W_FETCH    = {5'b10100, 4'b0000, 2'b01, 4'b0010, 3'b000, 4'd0};
    localparam logic [21:0] W_DECODE   = {5'b00000, 4'b0000, 2'b00, 4'b0000, 3'b000, 4'd1};
    localparam logic [21:0] W_EXEC_R2  = {5'b00000, 4'b0001, 2'b00, 4'b0010, 3'b000, 4'd2};
    localparam logic [21:0] W_WB_R     = {5'b00001, 4'b0010, 2'b00, 4'b0000, 3'b000, 4'd3};
    localparam logic [21:0] W_EXEC_I5  = {5'b00000, 4'b0001, 2'b10, 4'b0101, 3'b000, 4'd4};
    localparam logic [21:0] W_WB_I     = {5'b00001, 4'b0000, 2'b00, 4'b0000, 3'b000, 4'd5};
    localparam logic [21:0] W_MEM_ADDR = {5'b00000, 4'b0001, 2'b10, 4'b0010, 3'b000, 4'd6};
    localparam logic [21:0] W_MEM_RD   = {5'b00000, 4'b1000, 2'b00, 4'b0000, 3'b000, 4'd7};
    localparam logic [21:0] W_MEM_WB   = {5'b00001, 4'b0100, 2'b00, 4'b0000, 3'b000, 4'd8};
    localparam logic [21:0] W_MEM_WR   = {5'b00010, 4'b1000, 2'b00, 4'b0000, 3'b000, 4'd9};
    localparam logic [21:0] W_BEQ      = {5'b01000, 4'b0001, 2'b00, 4'b0110, 3'b000, 4'd10};
    localparam logic [21:0] W_BNE      = {5'b01000, 4'b0001, 2'b00, 4'b0110, 3'b010, 4'd10};
    localparam logic [21:0] W_JUMP     = {5'b10000, 4'b0000, 2'b00, 4'b0000, 3'b100, 4'd11};
    localparam logic [21:0] W_TRAP     = {5'b00000, 4'b0000, 2'b00, 4'b0000, 3'b001, 4'd12};
    localparam logic [21:0] W_RST_ADDR = {5'b00000, 4'b0000, 2'b00, 4'b0000, 3'b000, 4'd6};

    function automatic logic [21:0] obs();
        return {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_write, bus.reg_write,
                bus.iord, bus.mem_to_reg, bus.reg_dst, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_src, bus.beq_sel, bus.illegal, bus.state_dbg};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.run = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.run    = 1'b1;
        bus.opcode = 6'b000010;
        step();
        step();
        #1;
        n_checks++;
        if (obs() !== W_IDLE) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want %b", obs(), W_IDLE);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== W_FETCH) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", obs(), W_FETCH);
        end
        n_checks++;
        if (bus.instr_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", bus.instr_count);
        end
    endtask

    task automatic test_rtype();
        logic [21:0] exp [4];
        exp = '{W_FETCH, W_DECODE, W_EXEC_R2, W_WB_R};
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL rtype[%0d]: got %b want %b", i, obs(), exp[i]);
            end
            step();
            if (i == 1) bus.opcode = 6'b111111;
        end
        #1;
        n_checks++;
        if (bus.instr_count !== 32'd1) begin
            n_fail++;
            $display("FAIL rtype_count: got %0d want 1", bus.instr_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] exp [4];
        exp = '{W_FETCH, W_DECODE, W_EXEC_I5, W_WB_I};
        bus.opcode = 6'b010101;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL itype[%0d]: got %b want %b", i, obs(), exp[i]);
            end
            step();
            if (i == 1) bus.opcode = 6'b111111;
        end
        #1;
        n_checks++;
        if (bus.instr_count !== 32'd2) begin
            n_fail++;
            $display("FAIL itype_count: got %0d want 2", bus.instr_count);
        end
    endtask

    task automatic test_load_store();
        logic [21:0] exp_lw [5];
        logic [21:0] exp_sw [4];
        exp_lw = '{W_FETCH, W_DECODE, W_MEM_ADDR, W_MEM_RD, W_MEM_WB};
        exp_sw = '{W_FETCH, W_DECODE, W_MEM_ADDR, W_MEM_WR};
        do_reset();
        bus.run    = 1'b1;
        bus.opcode = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (obs() !== exp_lw[i]) begin
                n_fail++;
                $display("FAIL lw[%0d]: got %b want %b", i, obs(), exp_lw[i]);
            end
            step();
            if (i == 1) bus.opcode = 6'b111111;
        end
        #1;
        n_checks++;
        if (bus.instr_count !== 32'd1) begin
            n_fail++;
            $display("FAIL lw_count: got %0d want 1", bus.instr_count);
        end
        bus.opcode = 6'b100001;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (obs() !== exp_sw[i]) begin
                n_fail++;
                $display("FAIL sw[%0d]: got %b want %b", i, obs(), exp_sw[i]);
            end
            step();
            if (i == 1) bus.opcode = 6'b000000;
        end
        #1;
        n_checks++;
        if (bus.instr_count !== 32'd2) begin
            n_fail++;
            $display("FAIL sw_count: got %0d want 2", bus.instr_count);
        end
    endtask

    task automatic test_branch();
        logic [21:0] exp [2][3];
        logic [5:0]  ops [2];
        exp = '{'{W_FETCH, W_DECODE, W_BEQ}, '{W_FETCH, W_DECODE, W_BNE}};
        ops = '{6'b110000, 6'b110001};
        for (int b = 0; b < 2; b++) begin
            bus.opcode = ops[b];
            for (int i = 0; i < 3; i++) begin
                #1;
                n_checks++;
                if (obs() !== exp[b][i]) begin
                    n_fail++;
                    $display("FAIL branch%0d[%0d]: got %b want %b", b, i, obs(), exp[b][i]);
                end
                step();
                if (i == 1) bus.opcode = 6'b111111;
            end
            #1;
            n_checks++;
            if (bus.instr_count !== 32'(3 + b)) begin
                n_fail++;
                $display("FAIL branch%0d_count: got %0d want %0d", b, bus.instr_count, 3 + b);
            end
        end
    endtask

    task automatic test_jump_idle();
        logic [21:0] exp [3];
        exp = '{W_FETCH, W_DECODE, W_JUMP};
        bus.opcode = 6'b110010;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL jump[%0d]: got %b want %b", i, obs(), exp[i]);
            end
            step();
            if (i == 0) bus.run = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (obs() !== W_IDLE || bus.instr_count !== 32'd5) begin
                n_fail++;
                $display("FAIL idle[%0d]: got %b cnt %0d want %b cnt 5",
                         i, obs(), bus.instr_count, W_IDLE);
            end
            step();
        end
    endtask

    task automatic test_trap();
        bus.run    = 1'b1;
        bus.opcode = 6'b111111;
        #1;
        n_checks++;
        if (obs() !== W_FETCH) begin
            n_fail++;
            $display("FAIL trap_fetch: got %b want %b", obs(), W_FETCH);
        end
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            #1;
            n_checks++;
            if (obs() !== W_TRAP || bus.instr_count !== 32'd5) begin
                n_fail++;
                $display("FAIL trap[%0d]: got %b cnt %0d want %b cnt 5",
                         i, obs(), bus.instr_count, W_TRAP);
            end
            step();
        end
        reset   = 1'b1;
        bus.run = 1'b0;
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== W_IDLE || bus.instr_count !== 32'd0) begin
            n_fail++;
            $display("FAIL trap_reset: got %b cnt %0d want %b cnt 0",
                     obs(), bus.instr_count, W_IDLE);
        end
    endtask

    task automatic test_reset_mid_sw();
        bus.run    = 1'b1;
        bus.opcode = 6'b100001;
        step();
        step();
        #1;
        n_checks++;
        if (obs() !== W_MEM_ADDR) begin
            n_fail++;
            $display("FAIL rst_sw_addr: got %b want %b", obs(), W_MEM_ADDR);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs() !== W_RST_ADDR) begin
            n_fail++;
            $display("FAIL rst_sw_gate: got %b want %b", obs(), W_RST_ADDR);
        end
        step();
        reset   = 1'b0;
        bus.run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (obs() !== W_IDLE || bus.instr_count !== 32'd0) begin
                n_fail++;
                $display("FAIL rst_sw_after[%0d]: got %b cnt %0d want %b cnt 0",
                         i, obs(), bus.instr_count, W_IDLE);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        wbus.run    = 1'b1;
        wbus.opcode = 6'b110010;
        w_reset     = 1'b0;
        #1;
        n_checks++;
        if (wbus.instr_count !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_start: got %0d want 0", wbus.instr_count);
        end
        for (int j = 1; j <= 16; j++) begin
            step();
            step();
            step();
            n_checks++;
            if (wbus.instr_count !== 4'(j % 16) || wbus.state_dbg !== 4'd0) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got cnt %0d state %0d want cnt %0d state 0",
                         j, wbus.instr_count, wbus.state_dbg, j % 16);
            end
        end
    endtask

    initial begin
        bus.run     = 1'b0;
        bus.opcode  = 6'b0;
        wbus.run    = 1'b0;
        wbus.opcode = 6'b0;
        test_reset();
        test_rtype();
        test_back_to_back();
        test_load_store();
        test_branch();
        test_jump_idle();
        test_trap();
        test_reset_mid_sw();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
